// File: rtl/keypad_entry.sv
// rtl/keypad_entry.sv - 4x4 matrix keypad scanner, debouncer and BCD entry buffer
//
// Scans a 4x4 keypad one column per slot, debounces press and release, and
// assembles accepted digit keys into a packed BCD buffer.
//
// Optional feature macro: KEYPAD_BACKSPACE_EN
//   defined   : '*' removes the most recent digit (or clears after a '#')
//   undefined : '*' clears the whole buffer
//
// Parameters:
//   SCAN_DIV   - clk cycles per column slot
//   DEBOUNCE   - consecutive matching samples for press and for release
//   MAX_DIGITS - digit buffer capacity (1..7)
//
// Ports:
//   clk       - board clock, rising edge
//   enable    - asynchronous active-low reset
//   row       - keypad rows, active-low, sampled once per slot
//   col       - keypad column drive, active-low one-hot
//   clear     - single-cycle synchronous buffer clear
//   digits    - packed BCD buffer, [3:0] is the most recent digit
//   count     - number of valid digits
//   key_code  - code of the last accepted key
//   key_valid - one-cycle strobe per accepted key
//   done      - one-cycle strobe when '#' is accepted with count > 0

module keypad_entry #(
    parameter int SCAN_DIV   = 500000,
    parameter int DEBOUNCE   = 4,
    parameter int MAX_DIGITS = 5
) (
    input  logic                      clk,
    input  logic                      enable,
    input  logic [3:0]                row,
    output logic [3:0]                col,
    input  logic                      clear,
    output logic [4*MAX_DIGITS-1:0]   digits,
    output logic [2:0]                count,
    output logic [3:0]                key_code,
    output logic                      key_valid,
    output logic                      done
);

    localparam int BUF_W  = 4 * MAX_DIGITS;
    localparam int SLOT_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DB_W   = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;

    localparam logic [3:0] CODE_STAR = 4'd14;
    localparam logic [3:0] CODE_HASH = 4'd15;

    typedef enum logic [1:0] {
        ST_SCAN,
        ST_CONFIRM,
        ST_HELD,
        ST_RELEASE
    } state_t;

    state_t             state_q;
    logic [SLOT_W-1:0]  slot_cnt_q;
    logic [3:0]         col_q;
    logic [1:0]         col_idx_q;
    logic [1:0]         cand_row_q;
    logic [DB_W-1:0]    db_cnt_q;

    logic [BUF_W-1:0]   digits_q, digits_d;
    logic [2:0]         count_q, count_d;
    logic               post_done_q, post_done_d;
    logic               done_q, done_d;
    logic [3:0]         key_code_q;
    logic               key_valid_q;

    logic               sample_tick;
    logic               row_any;
    logic [1:0]         row_idx;
    logic               match;
    logic               db_done;
    logic               accept;
    logic [3:0]         acc_code;
    logic [BUF_W-1:0]   code_ext;

    // Physical key layout: (row, col) -> key code.
    function automatic logic [3:0] key_lookup(input logic [1:0] r, input logic [1:0] c);
        logic [3:0] k;
        k = 4'd0;
        case ({r, c})
            4'b00_00: k = 4'd1;
            4'b00_01: k = 4'd2;
            4'b00_10: k = 4'd3;
            4'b00_11: k = 4'd10;
            4'b01_00: k = 4'd4;
            4'b01_01: k = 4'd5;
            4'b01_10: k = 4'd6;
            4'b01_11: k = 4'd11;
            4'b10_00: k = 4'd7;
            4'b10_01: k = 4'd8;
            4'b10_10: k = 4'd9;
            4'b10_11: k = 4'd12;
            4'b11_00: k = CODE_STAR;
            4'b11_01: k = 4'd0;
            4'b11_10: k = CODE_HASH;
            default:  k = 4'd13;
        endcase
        return k;
    endfunction

    // Row sampling happens on the last cycle of each slot, so the column
    // drive has had a full slot to settle through the keypad.
    assign sample_tick = (slot_cnt_q == SLOT_W'(SCAN_DIV - 1));

    // Lowest low row wins when several rows are pulled down together.
    always_comb begin
        row_any = ~&row;
        row_idx = 2'd3;
        if (!row[0]) begin
            row_idx = 2'd0;
        end else if (!row[1]) begin
            row_idx = 2'd1;
        end else if (!row[2]) begin
            row_idx = 2'd2;
        end
    end

    assign match    = row_any && (row_idx == cand_row_q);
    assign db_done  = (db_cnt_q == DB_W'(DEBOUNCE - 1));
    assign accept   = sample_tick && (state_q == ST_CONFIRM) && match && db_done;
    assign acc_code = key_lookup(cand_row_q, col_idx_q);
    assign code_ext = BUF_W'(acc_code);

    // Entry buffer next state. A coincident clear overrides any key effect
    // on the buffer and suppresses done.
    always_comb begin
        digits_d    = digits_q;
        count_d     = count_q;
        post_done_d = post_done_q;
        done_d      = 1'b0;
        if (clear) begin
            digits_d    = '0;
            count_d     = 3'd0;
            post_done_d = 1'b0;
        end else if (accept) begin
            if (acc_code <= 4'd9) begin
                if (post_done_q) begin
                    // First digit after a completed entry starts a new one.
                    digits_d    = code_ext;
                    count_d     = 3'd1;
                    post_done_d = 1'b0;
                end else if (count_q < 3'(MAX_DIGITS)) begin
                    digits_d = (digits_q << 4) | code_ext;
                    count_d  = count_q + 3'd1;
                end
            end else if (acc_code == CODE_STAR) begin
`ifdef KEYPAD_BACKSPACE_EN
                if (post_done_q) begin
                    digits_d    = '0;
                    count_d     = 3'd0;
                    post_done_d = 1'b0;
                end else if (count_q != 3'd0) begin
                    digits_d = digits_q >> 4;
                    count_d  = count_q - 3'd1;
                end
`else
                digits_d    = '0;
                count_d     = 3'd0;
                post_done_d = 1'b0;
`endif
            end else if (acc_code == CODE_HASH) begin
                if (count_q != 3'd0) begin
                    done_d      = 1'b1;
                    post_done_d = 1'b1;
                end
            end
        end
    end

    // Scan/debounce FSM with registered outputs.
    always_ff @(posedge clk or negedge enable) begin
        if (!enable) begin
            state_q     <= ST_SCAN;
            slot_cnt_q  <= '0;
            col_q       <= 4'b1110;
            col_idx_q   <= 2'd0;
            cand_row_q  <= 2'd0;
            db_cnt_q    <= '0;
            digits_q    <= '0;
            count_q     <= 3'd0;
            post_done_q <= 1'b0;
            done_q      <= 1'b0;
            key_code_q  <= 4'd0;
            key_valid_q <= 1'b0;
        end else begin
            digits_q    <= digits_d;
            count_q     <= count_d;
            post_done_q <= post_done_d;
            done_q      <= done_d;
            key_valid_q <= accept;
            if (accept) begin
                key_code_q <= acc_code;
            end

            slot_cnt_q <= sample_tick ? '0 : slot_cnt_q + SLOT_W'(1);

            if (sample_tick) begin
                case (state_q)
                    ST_SCAN: begin
                        if (row_any) begin
                            state_q    <= ST_CONFIRM;
                            cand_row_q <= row_idx;
                            db_cnt_q   <= '0;
                        end else begin
                            col_q     <= {col_q[2:0], col_q[3]};
                            col_idx_q <= col_idx_q + 2'd1;
                        end
                    end
                    ST_CONFIRM: begin
                        if (match) begin
                            if (db_done) begin
                                state_q <= ST_HELD;
                            end else begin
                                db_cnt_q <= db_cnt_q + DB_W'(1);
                            end
                        end else begin
                            // Glitch or bounce: resume scanning past this column.
                            state_q   <= ST_SCAN;
                            col_q     <= {col_q[2:0], col_q[3]};
                            col_idx_q <= col_idx_q + 2'd1;
                        end
                    end
                    ST_HELD: begin
                        if (!row_any) begin
                            state_q  <= ST_RELEASE;
                            db_cnt_q <= '0;
                        end
                    end
                    ST_RELEASE: begin
                        if (row_any) begin
                            // Bounce during release; no new key is generated.
                            state_q <= ST_HELD;
                        end else if (db_done) begin
                            state_q   <= ST_SCAN;
                            col_q     <= {col_q[2:0], col_q[3]};
                            col_idx_q <= col_idx_q + 2'd1;
                        end else begin
                            db_cnt_q <= db_cnt_q + DB_W'(1);
                        end
                    end
                    default: begin
                        state_q <= ST_SCAN;
                    end
                endcase
            end
        end
    end

    assign col       = col_q;
    assign digits    = digits_q;
    assign count     = count_q;
    assign key_code  = key_code_q;
    assign key_valid = key_valid_q;
    assign done      = done_q;

endmodule

// File: tb/tb_keypad_entry.sv
// tb/tb_keypad_entry.sv - self-checking bench for keypad_entry with a physical keypad model
//
// The keypad is modelled as switches joining a column to a row: a pressed key
// pulls its row low whenever the DUT drives its column low. Expected buffer
// contents come from a queue-based entry model; expected accept timing comes
// from the rule "detected on the first sample of its column, accepted
// DEBOUNCE samples later".

module tb_keypad_entry;

    localparam int SCAN_DIV   = 4;
    localparam int DEBOUNCE   = 2;
    localparam int MAX_DIGITS = 5;
    localparam int BUF_W      = 4 * MAX_DIGITS;

    logic             clk;
    logic             enable;
    logic [3:0]       row;
    logic [3:0]       col;
    logic             clear;
    logic [BUF_W-1:0] digits;
    logic [2:0]       count;
    logic [3:0]       key_code;
    logic             key_valid;
    logic             done;

    keypad_entry #(
        .SCAN_DIV   (SCAN_DIV),
        .DEBOUNCE   (DEBOUNCE),
        .MAX_DIGITS (MAX_DIGITS)
    ) dut (
        .clk       (clk),
        .enable    (enable),
        .row       (row),
        .col       (col),
        .clear     (clear),
        .digits    (digits),
        .count     (count),
        .key_code  (key_code),
        .key_valid (key_valid),
        .done      (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Keypad stimulus state.
    bit         pressed   = 1'b0;
    int         p_row     = 0;
    int         p_col     = 0;
    bit         glitch_en = 1'b0;
    logic [3:0] glitch_row = 4'hF;

    always_comb begin
        row = 4'hF;
        if (glitch_en) begin
            row = glitch_row;
        end else if (pressed && (col[p_col] == 1'b0)) begin
            row = ~(4'b0001 << p_row);
        end
    end

    // Slot phase as seen from outside: starts at 0 out of reset.
    int ph = 0;
    always @(posedge clk or negedge enable) begin
        if (!enable) ph <= 0;
        else         ph <= (ph == SCAN_DIV - 1) ? 0 : ph + 1;
    end

    int kv_cnt = 0;
    int done_cnt = 0;
    always @(negedge clk) begin
        if (key_valid) kv_cnt <= kv_cnt + 1;
        if (done)      done_cnt <= done_cnt + 1;
    end

    // Entry reference model.
    int m_q[$];
    bit m_post = 1'b0;
    bit exp_done_last = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    function automatic void key_pos(input int code, output int r, output int c);
        case (code)
            1:  begin r = 0; c = 0; end
            2:  begin r = 0; c = 1; end
            3:  begin r = 0; c = 2; end
            10: begin r = 0; c = 3; end
            4:  begin r = 1; c = 0; end
            5:  begin r = 1; c = 1; end
            6:  begin r = 1; c = 2; end
            11: begin r = 1; c = 3; end
            7:  begin r = 2; c = 0; end
            8:  begin r = 2; c = 1; end
            9:  begin r = 2; c = 2; end
            12: begin r = 2; c = 3; end
            14: begin r = 3; c = 0; end
            0:  begin r = 3; c = 1; end
            15: begin r = 3; c = 2; end
            default: begin r = 3; c = 3; end
        endcase
    endfunction

    task automatic model_apply(input int code, input bit clr, output bit dn);
        dn = 1'b0;
        if (clr) begin
            m_q.delete();
            m_post = 1'b0;
        end else if (code <= 9) begin
            if (m_post) begin
                m_q.delete();
                m_post = 1'b0;
            end
            if (m_q.size() < MAX_DIGITS) m_q.push_back(code);
        end else if (code == 14) begin
`ifdef KEYPAD_BACKSPACE_EN
            if (m_post) begin
                m_q.delete();
                m_post = 1'b0;
            end else if (m_q.size() > 0) begin
                void'(m_q.pop_back());
            end
`else
            m_q.delete();
            m_post = 1'b0;
`endif
        end else if (code == 15) begin
            if (m_q.size() > 0) begin
                dn = 1'b1;
                m_post = 1'b1;
            end
        end
    endtask

    function automatic int model_digits();
        int v = 0;
        foreach (m_q[i]) v = (v << 4) | m_q[i];
        return v;
    endfunction

    // Press (or keep holding) a key and follow it to its accept edge.
    task automatic wait_accept(input int code, input bit clr);
        bit found = 1'b0;
        int kv0;
        bit dn;
        key_pos(code, p_row, p_col);
        pressed = 1'b1;
        kv0 = kv_cnt;
        exp_done_last = 1'b0;
        for (int n = 0; n < 8 * SCAN_DIV && !found; n++) begin
            if (ph == SCAN_DIV - 1 && col[p_col] == 1'b0) found = 1'b1;
            else tick();
        end
        check_eq("detect", 32'(found), 32'd1);
        if (!found) return;
        tick();
        for (int k = 1; k <= DEBOUNCE; k++) begin
            while (ph != SCAN_DIV - 1) tick();
            if (k == DEBOUNCE) clear = clr;
            tick();
        end
        clear = 1'b0;
        model_apply(code, clr, dn);
        exp_done_last = dn;
        check_eq("early_strobe", 32'(kv_cnt - kv0), 32'd0);
        check_eq("key_valid", 32'(key_valid), 32'd1);
        check_eq("key_code", 32'(key_code), 32'(code));
        check_eq("digits", 32'(digits), 32'(model_digits()));
        check_eq("count", 32'(count), 32'(m_q.size()));
        check_eq("done", 32'(done), 32'(dn));
    endtask

    task automatic press_key(input int code, input int hold, input bit clr);
        int kv0 = kv_cnt;
        int dn0 = done_cnt;
        wait_accept(code, clr);
        repeat (hold * SCAN_DIV) tick();
        pressed = 1'b0;
        repeat ((DEBOUNCE + 3) * SCAN_DIV) tick();
        check_eq("strobes", 32'(kv_cnt - kv0), 32'd1);
        check_eq("done_pulses", 32'(done_cnt - dn0), 32'(exp_done_last));
    endtask

    task automatic do_clear();
        clear = 1'b1;
        tick();
        clear = 1'b0;
        m_q.delete();
        m_post = 1'b0;
        check_eq("clear_count", 32'(count), 32'd0);
        check_eq("clear_digits", 32'(digits), 32'd0);
    endtask

    task automatic check_reset_outputs(input string tag);
        check_eq({tag, "_col"}, 32'(col), 32'h E);
        check_eq({tag, "_digits"}, 32'(digits), 32'd0);
        check_eq({tag, "_count"}, 32'(count), 32'd0);
        check_eq({tag, "_key_code"}, 32'(key_code), 32'd0);
        check_eq({tag, "_key_valid"}, 32'(key_valid), 32'd0);
        check_eq({tag, "_done"}, 32'(done), 32'd0);
    endtask

    initial begin
        int kv0;
        int code;
        logic [3:0] exp_col;

        enable = 1'b0;
        clear  = 1'b0;
        repeat (3) tick();
        check_reset_outputs("reset");
        enable = 1'b1;

        // Idle scanning: column walks c0..c3 once per slot, no strobes.
        kv0 = kv_cnt;
        for (int k = 0; k < 8; k++) begin
            exp_col = ~(4'b0001 << (k % 4));
            check_eq("idle_col", 32'(col), 32'(exp_col));
            repeat (SCAN_DIV) tick();
        end
        check_eq("idle_strobes", 32'(kv_cnt - kv0), 32'd0);
        check_eq("idle_done", 32'(done_cnt), 32'd0);

        // Key 5 held for several slots: one strobe only.
        press_key(5, 3, 1'b0);

        // Fill past capacity, complete with '#', then a new digit restarts.
        do_clear();
        for (int d = 1; d <= 6; d++) press_key(d, 1, 1'b0);
        check_eq("buf_12345", 32'(digits), 32'h12345);
        press_key(15, 1, 1'b0);
        press_key(9, 1, 1'b0);
        check_eq("buf_9", 32'(digits), 32'h9);

        // '*' behaviour, then '#' with whatever is left.
        do_clear();
        press_key(4, 1, 1'b0);
        press_key(7, 1, 1'b0);
        press_key(14, 1, 1'b0);
        press_key(15, 1, 1'b0);

        // One-sample row glitch while c2 is driven.
        kv0 = kv_cnt;
        for (int n = 0; n < 8 * SCAN_DIV; n++) begin
            if (ph == SCAN_DIV - 1 && col == 4'b1011) break;
            tick();
        end
        check_eq("glitch_at_c2", 32'(col), 32'hB);
        glitch_row = 4'b1101;
        glitch_en  = 1'b1;
        tick();
        glitch_en  = 1'b0;
        check_eq("glitch_col_frozen", 32'(col), 32'hB);
        while (ph != SCAN_DIV - 1) tick();
        tick();
        check_eq("glitch_resume_c3", 32'(col), 32'h7);
        repeat (4 * SCAN_DIV) tick();
        check_eq("glitch_no_strobe", 32'(kv_cnt - kv0), 32'd0);

        // Clear coinciding with a digit accept.
        press_key(2, 1, 1'b0);
        press_key(3, 1, 1'b1);

        // Reset asserted while a key is held, then released with the key still down.
        wait_accept(8, 1'b0);
        repeat (SCAN_DIV) tick();
        #2 enable = 1'b0;
        #1;
        check_reset_outputs("mid_reset");
        m_q.delete();
        m_post = 1'b0;
        tick();
        tick();
        enable = 1'b1;
        press_key(8, 1, 1'b0);

        // Randomized key sequences.
        for (int i = 0; i < 40; i++) begin
            if ($urandom_range(1, 0) == 0) code = int'($urandom_range(9, 0));
            else                            code = int'($urandom_range(15, 0));
            if ($urandom_range(9, 0) == 0) do_clear();
            press_key(code, int'($urandom_range(3, 1)), ($urandom_range(7, 0) == 0));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/keypad_entry.md
# keypad_entry

Matrix-keypad front end for the parking controller: scans the 4x4 keypad, debounces presses, and assembles them into a multi-digit BCD entry (stall IDs, durations) for the controller FSM. It drives the keypad column lines and reads the row lines. It delivers a packed digit buffer, a digit count, a per-key strobe and an entry-complete strobe, all synchronous to the 100 MHz board clock.

## Interface
- `SCAN_DIV`, default 500000: clk cycles per column slot (5 ms at 100 MHz).
- `DEBOUNCE`, default 4: consecutive matching samples required for both press and release.
- `MAX_DIGITS`, default 5: capacity of the digit buffer, range 1–7.
- `clk`, input, 1: board clock; all logic on its rising edge.
- `enable`, input, 1: asynchronous, active-low reset; low clears all state.
- `row`, input, 4: keypad rows, active-low (pulled up), sampled only.
- `col`, output, 4: keypad column drive, active-low one-hot.
- `clear`, input, 1: synchronous single-cycle buffer clear from a debounced button.
- `digits`, output, 4*MAX_DIGITS: BCD buffer; `[3:0]` holds the most recent digit.
- `count`, output, 3: number of valid digits, 0..MAX_DIGITS.
- `key_code`, output, 4: code of the last accepted key; holds until the next accepted key.
- `key_valid`, output, 1: one-cycle strobe per accepted press.
- `done`, output, 1: one-cycle strobe when `#` is pressed with count>0.

## Operation
- Keymap by (row,col):
  - r0: 1, 2, 3, A
  - r1: 4, 5, 6, B
  - r2: 7, 8, 9, C
  - r3: \*, 0, #, D
- Codes: digits 0–9, A–D = 10–13, \* = 14, # = 15.
- Scan FSM states:
  - SCAN: step `col` through c0→c1→c2→c3→c0. Sample `row` once per slot. Any low row moves to CONFIRM with that (row,col) as candidate. If several rows are low, the lowest row index wins.
  - CONFIRM: `col` frozen. Matching sample increments the match count. At DEBOUNCE matches, accept the key and go to HELD. A mismatch or all-high sample returns to SCAN and advances to the next column.
  - HELD: `col` frozen. The first all-high sample moves to RELEASE.
  - RELEASE: DEBOUNCE consecutive all-high samples return to SCAN on the next column. Any low sample returns to HELD with no new key (no auto-repeat).
- Entry rules on accept (`key_valid` always pulses):
  - Digit, count<MAX_DIGITS: shift `digits` left 4 bits, insert code at `[3:0]`, increment count.
  - Digit, count=MAX_DIGITS: buffer unchanged.
  - Digit with the post-done flag set: clear the buffer first, then load the digit (count becomes 1).
  - \*: see Configuration.
  - # with count>0: pulse `done`, set the post-done flag; buffer holds.
  - # with count=0: no `done`.
  - A–D: no buffer effect.
- `clear`: zeros `digits` and `count` and drops the post-done flag. If it coincides with an accept, clear wins for the buffer; `key_valid`/`key_code` still reflect the key; `done` is suppressed.

## Timing
- Reset values: `col`=4'b1110, `digits`=0, `count`=0, `key_code`=0, `key_valid`=0, `done`=0; FSM in SCAN with slot counter at 0.
- Slot counter runs 0..SCAN_DIV-1. `row` is sampled at SCAN_DIV-1, giving a full slot of settling.
- `col` changes on the wrap edge.
- Accept latency: `key_valid`, `key_code`, `digits`, `count` and `done` all update on the clk edge following the DEBOUNCE-th matching sample. They appear together, with no extra pipeline stage.
- Minimum press-to-strobe time: DEBOUNCE slots after the press is first sampled.
- `enable` low mid-press: immediate return to reset values. After release of reset, a key still held is re-detected as a new press.

## Configuration
- `KEYPAD_BACKSPACE_EN` defined:
  - \* is backspace: shift `digits` right 4 bits with zero fill, decrement count.
  - No-op at count=0.
  - With the post-done flag set, \* clears the buffer.
- `KEYPAD_BACKSPACE_EN` undefined: \* clears the whole buffer (count=0) regardless of state.

## Test plan
All scenarios use SCAN_DIV=4, DEBOUNCE=2, MAX_DIGITS=5.
- Reset, no key: `col` cycles 1110→1101→1011→0111 every 4 clk; all strobes stay 0.
- Hold r1 low while c1 is driven (key 5) for 3 slots: `key_valid`=1 for one cycle, `key_code`=5, `digits[3:0]`=5, `count`=1; no second strobe while held.
- Enter 1,2,3,4,5,6: `count`=5, `digits`=0x12345, key 6 gives `key_valid` only. Then #: `done` pulses. Then 9: `count`=1, `digits`=0x00009.
- Enter 4,7 then \*:
  - Macro defined: `digits`=0x4, `count`=1.
  - Macro undefined: `count`=0.
  - # at count=0: no `done`.
- Row glitch of one sample on c2: no `key_valid`; scanning resumes at c3.
- `clear` on the same cycle as a digit accept: `count`=0, `key_valid`=1.
- `enable` dropped while in HELD: outputs return to reset values at once.
